// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the up/down counter family.
// Boundary-mode encodings and the load/parameter clamp live here so every user agrees.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic longint unsigned clamp_to_max(input longint unsigned value,
                                                   input longint unsigned max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-state for mod_updown_counter: load clamp, step, and boundary events.
// Arithmetic is carried in WIDTH+1 bits so the bound test never depends on 2**WIDTH.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int              MODE      = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             sat_evt
);

  localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] inc_w;
  logic [WIDTH:0] dec_w;
  logic           up_bound;
  logic           down_bound;

  assign count_ext  = {1'b0, count};
  assign inc_w      = count_ext + (WIDTH+1)'(1);
  assign dec_w      = count_ext - (WIDTH+1)'(1);
  // Past the top when the incremented value exceeds the bound; borrow-out marks the bottom.
  assign up_bound   = (inc_w > MAX_W);
  assign down_bound = dec_w[WIDTH];

  always_comb begin
    next_count = count;
    wrap_evt   = 1'b0;
    sat_evt    = 1'b0;
    if (i_load) begin
      next_count = WIDTH'(clamp_to_max(64'(i_load_value), MAX_VALUE));
    end else if (i_en) begin
      if (i_up) begin
        if (!up_bound) begin
          next_count = inc_w[WIDTH-1:0];
        end else if (MODE == MODE_SAT) begin
          next_count = MAX_CNT;
          sat_evt    = 1'b1;
        end else begin
          next_count = '0;
          wrap_evt   = 1'b1;
        end
      end else begin
        if (!down_bound) begin
          next_count = dec_w[WIDTH-1:0];
        end else if (MODE == MODE_SAT) begin
          next_count = '0;
          sat_evt    = 1'b1;
        end else begin
          next_count = MAX_CNT;
          wrap_evt   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate bounds and registered event pulses.
// Holds the state registers, the async reset and the bound decode.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH       = 4,
  parameter longint unsigned MAX_VALUE   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VALUE = 64'd0,
  parameter int              MODE        = MODE_WRAP
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_sat,
  output logic             o_at_max,
  output logic             o_at_min
);

  localparam longint unsigned WIDTH_MAX = (64'd1 << WIDTH) - 64'd1;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be 1..32");
  end
  if (clamp_to_max(MAX_VALUE, WIDTH_MAX) != MAX_VALUE) begin : g_bad_max
    $error("mod_updown_counter: MAX_VALUE does not fit in WIDTH bits");
  end
  if (clamp_to_max(RESET_VALUE, MAX_VALUE) != RESET_VALUE) begin : g_bad_reset
    $error("mod_updown_counter: RESET_VALUE exceeds MAX_VALUE");
  end
  if (MODE != MODE_WRAP && MODE != MODE_SAT) begin : g_bad_mode
    $error("mod_updown_counter: MODE must be MODE_WRAP or MODE_SAT");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  counter_next_calc #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAX_VALUE),
    .MODE      (MODE)
  ) u_next (
    .count        (count_q),
    .i_en         (i_en),
    .i_up         (i_up),
    .i_load       (i_load),
    .i_load_value (i_load_value),
    .next_count   (count_d),
    .wrap_evt     (wrap_d),
    .sat_evt      (sat_d)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= WIDTH'(RESET_VALUE);
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign o_count  = count_q;
  assign o_wrap   = wrap_q;
  assign o_sat    = sat_q;
  assign o_at_max = (count_q == WIDTH'(MAX_VALUE));
  assign o_at_min = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter across wrap, saturate, reset-value and MAX=0 builds.
module tb_mod_updown_counter;

  logic clk;
  logic rst;

  logic       a_en, a_up, a_load;
  logic [3:0] a_lv, a_cnt;
  logic       a_wrap, a_sat, a_max, a_min;

  logic       b_en, b_up, b_load;
  logic [3:0] b_lv, b_cnt;
  logic       b_wrap, b_sat, b_max, b_min;

  logic       c_en, c_up, c_load;
  logic [3:0] c_lv, c_cnt;
  logic       c_wrap, c_sat, c_max, c_min;

  logic       d_en, d_up, d_load;
  logic [1:0] d_lv, d_cnt;
  logic       d_wrap, d_sat, d_max, d_min;

  int total = 0;
  int bad   = 0;

  mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .RESET_VALUE(0), .MODE(0)) u_a (
    .i_clk(clk), .i_reset(rst), .i_en(a_en), .i_up(a_up), .i_load(a_load),
    .i_load_value(a_lv), .o_count(a_cnt), .o_wrap(a_wrap), .o_sat(a_sat),
    .o_at_max(a_max), .o_at_min(a_min));

  mod_updown_counter #(.WIDTH(4), .MAX_VALUE(15), .RESET_VALUE(0), .MODE(1)) u_b (
    .i_clk(clk), .i_reset(rst), .i_en(b_en), .i_up(b_up), .i_load(b_load),
    .i_load_value(b_lv), .o_count(b_cnt), .o_wrap(b_wrap), .o_sat(b_sat),
    .o_at_max(b_max), .o_at_min(b_min));

  mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .RESET_VALUE(5), .MODE(0)) u_c (
    .i_clk(clk), .i_reset(rst), .i_en(c_en), .i_up(c_up), .i_load(c_load),
    .i_load_value(c_lv), .o_count(c_cnt), .o_wrap(c_wrap), .o_sat(c_sat),
    .o_at_max(c_max), .o_at_min(c_min));

  mod_updown_counter #(.WIDTH(2), .MAX_VALUE(0), .RESET_VALUE(0), .MODE(0)) u_d (
    .i_clk(clk), .i_reset(rst), .i_en(d_en), .i_up(d_up), .i_load(d_load),
    .i_load_value(d_lv), .o_count(d_cnt), .o_wrap(d_wrap), .o_sat(d_sat),
    .o_at_max(d_max), .o_at_min(d_min));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {a_en, a_up, a_load, a_lv} = '0;
    {b_en, b_up, b_load, b_lv} = '0;
    {c_en, c_up, c_load, c_lv} = '0;
    {d_en, d_up, d_load, d_lv} = '0;
    #3;
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_wrap", a_wrap, 0);
    chk("rst_a_min", a_min, 1);
    chk("rst_c_cnt", c_cnt, 5);
    chk("rst_b_sat", b_sat, 0);
    step();
    rst = 1'b0;

    // Wrap mode count up through the bound.
    a_en = 1; a_up = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("up_cnt", a_cnt, (i + 1) % 10);
      chk("up_wrap", a_wrap, ((i + 1) % 10) == 0);
      chk("up_max", a_max, ((i + 1) % 10) == 9);
    end

    // Load 1 then count down through zero.
    a_en = 0; a_load = 1; a_lv = 4'd1;
    step();
    chk("ld1_cnt", a_cnt, 1);
    a_load = 0; a_en = 1; a_up = 0;
    step();
    chk("dn_cnt0", a_cnt, 0);
    chk("dn_wrap0", a_wrap, 0);
    chk("dn_min0", a_min, 1);
    step();
    chk("dn_cnt9", a_cnt, 9);
    chk("dn_wrap9", a_wrap, 1);
    step();
    chk("dn_cnt8", a_cnt, 8);
    chk("dn_wrap8", a_wrap, 0);

    // Load beats enable, and clamps to MAX.
    a_load = 1; a_en = 1; a_up = 1; a_lv = 4'd12;
    step();
    chk("ldclamp_cnt", a_cnt, 9);
    chk("ldclamp_wrap", a_wrap, 0);
    a_load = 0; a_en = 0;
    step();
    chk("hold_cnt", a_cnt, 9);

    // Enable gating with direction toggling.
    for (int i = 0; i < 5; i++) begin
      a_up = i[0];
      step();
      chk("gate_cnt", a_cnt, 9);
      chk("gate_wrap", a_wrap, 0);
      chk("gate_sat", a_sat, 0);
    end

    // Saturate mode at the top and bottom.
    b_load = 1; b_lv = 4'd14;
    step();
    chk("sat_ld", b_cnt, 14);
    b_load = 0; b_en = 1; b_up = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sat_up_cnt", b_cnt, 15);
      chk("sat_up_sat", b_sat, i > 0);
      chk("sat_up_wrap", b_wrap, 0);
    end
    b_en = 0; b_load = 1; b_lv = 4'd0;
    step();
    chk("sat_ld0", b_cnt, 0);
    chk("sat_ld0_sat", b_sat, 0);
    b_load = 0; b_en = 1; b_up = 0;
    step();
    chk("sat_dn_cnt", b_cnt, 0);
    chk("sat_dn_sat", b_sat, 1);
    chk("sat_dn_wrap", b_wrap, 0);
    b_en = 0;
    step();
    chk("sat_idle_sat", b_sat, 0);

    // MAX_VALUE=0: every enabled step wraps.
    d_en = 1; d_up = 1;
    step();
    chk("deg_up_cnt", d_cnt, 0);
    chk("deg_up_wrap", d_wrap, 1);
    d_up = 0;
    step();
    chk("deg_dn_wrap", d_wrap, 1);
    chk("deg_maxmin", {d_max, d_min}, 2'b11);
    d_en = 0;
    step();
    chk("deg_idle_wrap", d_wrap, 0);

    // Async reset mid-count on the RESET_VALUE=5 build.
    c_en = 1; c_up = 1;
    step();
    chk("c_cnt6", c_cnt, 6);
    step();
    chk("c_cnt7", c_cnt, 7);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cnt", c_cnt, 5);
    chk("arst_wrap", c_wrap, 0);
    chk("arst_sat", c_sat, 0);
    rst = 1'b0;
    step();
    chk("arst_after", c_cnt, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
